// File: rtl/gf_pkg.sv
// Shared types and encodings for the sequential GF(2^m) arithmetic unit.
package gf_pkg;

    // Operation encodings on the mode input.
    localparam logic [1:0] MODE_ENC_MUL  = 2'd0;
    localparam logic [1:0] MODE_ENC_SQR  = 2'd1;
    localparam logic [1:0] MODE_ENC_EXP  = 2'd2;
    localparam logic [1:0] MODE_ENC_RSVD = 2'd3;

    typedef enum logic [1:0] {
        MODE_MUL  = MODE_ENC_MUL,
        MODE_SQR  = MODE_ENC_SQR,
        MODE_EXP  = MODE_ENC_EXP,
        MODE_RSVD = MODE_ENC_RSVD
    } mode_t;

    // ST_SEL is the exponent-bit selection point. It is resolved in the
    // final MUL_RUN cycle of each multiply so no bubble cycle is spent there.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_SEL     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/gf_mul_step.sv
// One MSB-first interleaved multiply-and-reduce step:
// acc' = (acc << 1) ^ (acc[msb] ? p : 0) ^ (op2_bit ? op1 : 0).
module gf_mul_step #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic                  op2_bit,
    input  logic [DATA_WIDTH-1:0] poly,
    output logic [DATA_WIDTH-1:0] acc_next
);

    // Shift, fold the overflowing x^m term back through p, add partial product.
    always_comb begin
        acc_next = {acc[DATA_WIDTH-2:0], 1'b0};
        if (acc[DATA_WIDTH-1]) begin
            acc_next = acc_next ^ poly;
        end
        if (op2_bit) begin
            acc_next = acc_next ^ op1;
        end
    end

endmodule

// File: rtl/gf_seq_exp_unit.sv
// Sequential GF(2^m) multiply / square / exponentiate unit with a bit-serial
// interleaved core and a left-to-right square-and-multiply controller.
// Handshake: a request is taken on a rising edge where start=1 and ready=1;
// ready is low while busy; done is a one-cycle pulse in which out is valid
// and ready is already high again, so a new start in that cycle is accepted.
module gf_seq_exp_unit
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int EXP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [EXP_WIDTH-1:0]  e,
    input  logic [DATA_WIDTH:0]   polyn_red_in,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(EXP_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state, state_next;
    mode_t                 mode_r;
    logic [DATA_WIDTH-1:0] a_r, p_r, op1, op2, acc, res, prod;
    logic [EXP_WIDTH-1:0]  e_r;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  sq_phase;
    logic                  last_bit, take_mul, finish;

    // The implied x^m coefficient of p is never looked at.
    logic unused_poly_top;
    assign unused_poly_top = polyn_red_in[DATA_WIDTH];

    gf_mul_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .acc      (acc),
        .op1      (op1),
        .op2_bit  (op2[cnt]),
        .poly     (p_r),
        .acc_next (prod)
    );

    // Selection logic evaluated during the last bit of every multiply.
    always_comb begin
        last_bit = (cnt == '0);
        take_mul = (mode_r == MODE_EXP) && sq_phase && e_r[idx];
        finish   = (mode_r != MODE_EXP) || (!take_mul && (idx == '0));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and ready decode.
    always_comb begin
        state_next = state;
        ready      = (state == ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (mode_t'(mode) == MODE_RSVD) ? ST_DONE : ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: begin
                if (last_bit) begin
                    state_next = finish ? ST_DONE : ST_MUL_RUN;
                end
            end
            // Never entered: the SEL decision is folded into MUL_RUN.
            ST_SEL:  state_next = ST_IDLE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, core accumulation, exponent walk and result output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= MODE_MUL;
            a_r      <= '0;
            e_r      <= '0;
            p_r      <= '0;
            op1      <= '0;
            op2      <= '0;
            acc      <= '0;
            cnt      <= '0;
            idx      <= '0;
            sq_phase <= 1'b0;
            res      <= '0;
            out      <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r   <= mode_t'(mode);
                        a_r      <= a;
                        e_r      <= e;
                        p_r      <= polyn_red_in[DATA_WIDTH-1:0];
                        acc      <= '0;
                        cnt      <= CNT_TOP;
                        idx      <= IDX_TOP;
                        sq_phase <= 1'b1;
                        case (mode_t'(mode))
                            MODE_MUL: begin op1 <= a;   op2 <= b;   end
                            MODE_SQR: begin op1 <= a;   op2 <= a;   end
                            MODE_EXP: begin op1 <= ONE; op2 <= ONE; end
                            default:  begin op1 <= '0;  op2 <= '0;  res <= '0; end
                        endcase
                    end
                end
                ST_MUL_RUN: begin
                    if (!last_bit) begin
                        acc <= prod;
                        cnt <= cnt - 1'b1;
                    end else begin
                        acc <= '0;
                        cnt <= CNT_TOP;
                        if (finish) begin
                            res <= prod;
                        end else if (take_mul) begin
                            op1      <= prod;
                            op2      <= a_r;
                            sq_phase <= 1'b0;
                        end else begin
                            op1      <= prod;
                            op2      <= prod;
                            idx      <= idx - 1'b1;
                            sq_phase <= 1'b1;
                        end
                    end
                end
                ST_DONE: out <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_seq_exp_unit.sv
// Directed bench for gf_seq_exp_unit with W=4, p = x^4 + x + 1 (19).
module tb_gf_seq_exp_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [3:0] a, b;
    logic [3:0] e;
    logic [4:0] polyn_red_in;
    logic       ready, done;
    logic [3:0] out;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_dones = 0;

    typedef struct {
        logic [1:0] m;
        logic [3:0] va;
        logic [3:0] vb;
        logic [3:0] ve;
        logic [3:0] exp_out;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    gf_seq_exp_unit #(.DATA_WIDTH(4), .EXP_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .a            (a),
        .b            (b),
        .e            (e),
        .polyn_red_in (polyn_red_in),
        .ready        (ready),
        .done         (done),
        .out          (out)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Driver: called at a negedge; issues one request and waits for done.
    // Returns at the negedge in which done is seen, i.e. the done cycle.
    task automatic do_op(input logic [1:0] m, input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] ve, input bit disturb,
                         output logic [3:0] res, output int lat);
        lat = -1;
        res = 'x;
        check("ready_before_start", int'(ready), 1);
        start = 1'b1; mode = m; a = va; b = vb; e = ve;
        exp_dones++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 200; j++) begin
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                mode = 2'($urandom_range(0, 3));
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                e = 4'($urandom_range(0, 15));
                polyn_red_in = 5'($urandom_range(0, 31));
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = j;
                res = out;
                start = 1'b0;
                polyn_red_in = 5'd19;
                break;
            end
        end
        start = 1'b0;
        polyn_red_in = 5'd19;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    initial begin
        logic [3:0] r;
        int         lat;
        int         dc;

        vecs[0] = '{2'd0, 4'd12, 4'd10, 4'd0,  4'd1,  5};
        vecs[1] = '{2'd1, 4'd12, 4'd0,  4'd0,  4'd15, 5};
        vecs[2] = '{2'd2, 4'd12, 4'd0,  4'd14, 4'd10, 29};
        vecs[3] = '{2'd2, 4'd2,  4'd0,  4'd4,  4'd3,  21};
        vecs[4] = '{2'd2, 4'd7,  4'd0,  4'd0,  4'd1,  17};
        vecs[5] = '{2'd2, 4'd0,  4'd0,  4'd5,  4'd0,  25};
        vecs[6] = '{2'd3, 4'd9,  4'd9,  4'd9,  4'd0,  1};
        vecs[7] = '{2'd0, 4'd3,  4'd7,  4'd0,  4'd9,  5};
        vecs[8] = '{2'd1, 4'd2,  4'd0,  4'd0,  4'd4,  5};
        vecs[9] = '{2'd0, 4'd15, 4'd1,  4'd0,  4'd15, 5};

        rst = 1'b1; start = 1'b0; mode = 2'd0; a = '0; b = '0; e = '0;
        polyn_red_in = 5'd19;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_out", int'(out), 0);
        rst = 1'b0;
        @(negedge clk);

        // table-driven vectors, issued back to back
        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].va, vecs[i].vb, vecs[i].ve, 1'b0, r, lat);
            check($sformatf("vec%0d_out", i), int'(r), int'(vecs[i].exp_out));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // idle gap, then a^15 = 1 for every nonzero a
        repeat (3) @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            do_op(2'd2, 4'(i), 4'd0, 4'd15, 1'b0, r, lat);
            check($sformatf("exp15_a%0d", i), int'(r), 1);
            check($sformatf("exp15_lat_a%0d", i), lat, 33);
        end

        // chain: a^14 then (a^14)*a, started in the done cycle
        do_op(2'd2, 4'd12, 4'd0, 4'd14, 1'b0, r, lat);
        check("chain_inv", int'(r), 10);
        do_op(2'd0, r, 4'd12, 4'd0, 1'b0, r, lat);
        check("chain_prod", int'(r), 1);
        check("chain_lat", lat, 5);
        do_op(2'd2, 4'd9, 4'd0, 4'd14, 1'b0, r, lat);
        do_op(2'd0, r, 4'd9, 4'd0, 1'b0, r, lat);
        check("chain_prod_a9", int'(r), 1);

        // inputs and start churned while busy
        do_op(2'd2, 4'd12, 4'd0, 4'd14, 1'b1, r, lat);
        check("disturb_exp_out", int'(r), 10);
        check("disturb_exp_lat", lat, 29);
        do_op(2'd0, 4'd12, 4'd10, 4'd0, 1'b1, r, lat);
        check("disturb_mul_out", int'(r), 1);
        check("disturb_mul_lat", lat, 5);
        @(negedge clk);
        check("out_held", int'(out), 1);
        check("done_pulse_one_cycle", int'(done), 0);

        // reset in the middle of an EXP
        dc = done_cnt;
        start = 1'b1; mode = 2'd2; a = 4'd12; e = 4'd14;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_ready", int'(ready), 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_out", int'(out), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_cnt, dc);
        do_op(2'd0, 4'd12, 4'd10, 4'd0, 1'b0, r, lat);
        check("post_rst_mul", int'(r), 1);
        check("post_rst_lat", lat, 5);
        do_op(2'd3, 4'd5, 4'd5, 4'd5, 1'b0, r, lat);
        check("rsvd_out", int'(r), 0);
        check("rsvd_lat", lat, 1);

        repeat (5) @(negedge clk);
        check("done_count", done_cnt, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
